// File: rtl/ea_sequencer.sv
// Effective-address sequencer for the 2A03 core. It fetches operand bytes, follows
// zero-page pointers and borrows the shared ALU for index adds and high-byte fixups.
module ea_sequencer #(
    parameter logic [7:0] ALU_OP_ADDR = 8'b1000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  mode,
    input  logic        is_write,
    input  logic [7:0]  index_x,
    input  logic [7:0]  index_y,
    input  logic [15:0] pc,
    output logic        pc_inc,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_data,
    input  logic        mem_ready,
    output logic        alu_req,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [7:0]  alu_op,
    input  logic [8:0]  alu_f,
    output logic        busy,
    output logic [15:0] ea,
    output logic        ea_valid,
    output logic        page_cross
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FETCH_LO = 3'd1;
    localparam logic [2:0] S_FETCH_HI = 3'd2;
    localparam logic [2:0] S_ADD_LO   = 3'd3;
    localparam logic [2:0] S_FIX_HI   = 3'd4;
    localparam logic [2:0] S_PTR_LO   = 3'd5;
    localparam logic [2:0] S_PTR_HI   = 3'd6;
    localparam logic [2:0] S_DONE     = 3'd7;

    logic [2:0]  state_q, state_d;
    logic [2:0]  mode_q, mode_d;
    logic        wr_q, wr_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  lo_q, lo_d;
    logic [7:0]  hi_q, hi_d;
    logic [7:0]  ptr_q, ptr_d;
    logic        carry_q, carry_d;
    logic [15:0] ea_q, ea_d;
    logic        pcross_q, pcross_d;
    logic [7:0]  ptr_inc;
    logic        fetch_st;
    logic        add_st;
    logic        fix_st;

    assign ptr_inc  = ptr_q + 8'd1;
    assign fetch_st = (state_q == S_FETCH_LO) || (state_q == S_FETCH_HI);
    assign add_st   = (state_q == S_ADD_LO);
    assign fix_st   = (state_q == S_FIX_HI);

    always_comb begin
        mem_rd   = 1'b0;
        mem_addr = 16'h0000;
        case (state_q)
            S_FETCH_LO, S_FETCH_HI: begin
                mem_rd   = 1'b1;
                mem_addr = pc;
            end
            S_PTR_LO: begin
                mem_rd   = 1'b1;
                mem_addr = {8'h00, ptr_q};
            end
            S_PTR_HI: begin
                mem_rd   = 1'b1;
                mem_addr = {8'h00, ptr_inc};
            end
            default: ;
        endcase
    end

    assign pc_inc     = fetch_st && mem_ready;
    assign alu_req    = add_st || fix_st;
    assign alu_a      = add_st ? lo_q : (fix_st ? hi_q : 8'h00);
    assign alu_b      = add_st ? idx_q : (fix_st ? {7'd0, carry_q} : 8'h00);
    assign alu_op     = alu_req ? ALU_OP_ADDR : 8'h00;
    assign busy       = (state_q != S_IDLE);
    assign ea_valid   = (state_q == S_DONE);
    // Outside DONE the address and flag of the last completed sequence stay visible.
    assign ea         = ea_valid ? {hi_q, lo_q} : ea_q;
    assign page_cross = ea_valid ? carry_q : pcross_q;

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        wr_d     = wr_q;
        idx_d    = idx_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        ptr_d    = ptr_q;
        carry_d  = carry_q;
        ea_d     = ea_q;
        pcross_d = pcross_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    wr_d    = is_write;
                    lo_d    = 8'h00;
                    hi_d    = 8'h00;
                    ptr_d   = 8'h00;
                    carry_d = 1'b0;
                    case (mode)
                        3'd1, 3'd4, 3'd6: idx_d = index_x;
                        3'd2, 3'd5, 3'd7: idx_d = index_y;
                        default:          idx_d = 8'h00;
                    endcase
                    state_d = S_FETCH_LO;
                end
            end
            S_FETCH_LO: begin
                if (mem_ready) begin
                    if (mode_q == 3'd7) begin
                        ptr_d   = mem_data;
                        state_d = S_PTR_LO;
                    end else begin
                        lo_d = mem_data;
                        case (mode_q)
                            3'd0:             state_d = S_DONE;
                            3'd1, 3'd2, 3'd6: state_d = S_ADD_LO;
                            default:          state_d = S_FETCH_HI;
                        endcase
                    end
                end
            end
            S_FETCH_HI: begin
                if (mem_ready) begin
                    hi_d    = mem_data;
                    state_d = (mode_q == 3'd3) ? S_DONE : S_ADD_LO;
                end
            end
            S_ADD_LO: begin
                // Zero-page forms drop the carry so the sum wraps inside page zero.
                if (mode_q == 3'd6) begin
                    ptr_d   = alu_f[7:0];
                    state_d = S_PTR_LO;
                end else if (mode_q == 3'd1 || mode_q == 3'd2) begin
                    lo_d    = alu_f[7:0];
                    state_d = S_DONE;
                end else begin
                    lo_d    = alu_f[7:0];
                    carry_d = alu_f[8];
                    state_d = (alu_f[8] || wr_q) ? S_FIX_HI : S_DONE;
                end
            end
            S_FIX_HI: begin
                hi_d    = alu_f[7:0];
                state_d = S_DONE;
            end
            S_PTR_LO: begin
                if (mem_ready) begin
                    lo_d    = mem_data;
                    state_d = S_PTR_HI;
                end
            end
            S_PTR_HI: begin
                if (mem_ready) begin
                    hi_d    = mem_data;
                    state_d = (mode_q == 3'd7) ? S_ADD_LO : S_DONE;
                end
            end
            S_DONE: begin
                ea_d     = {hi_q, lo_q};
                pcross_d = carry_q;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            mode_q   <= 3'd0;
            wr_q     <= 1'b0;
            idx_q    <= 8'h00;
            lo_q     <= 8'h00;
            hi_q     <= 8'h00;
            ptr_q    <= 8'h00;
            carry_q  <= 1'b0;
            ea_q     <= 16'h0000;
            pcross_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            wr_q     <= wr_d;
            idx_q    <= idx_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            ptr_q    <= ptr_d;
            carry_q  <= carry_d;
            ea_q     <= ea_d;
            pcross_q <= pcross_d;
        end
    end

endmodule

// File: doc/ea_sequencer.md
Name: ea_sequencer

Overview:
- Multi-cycle effective-address sequencer for the 2A03 core.
- Fetches operand bytes, reads zero-page pointers and drives the shared 8-bit ALU in address-calc add mode for index adds and high-byte fixups.
- Presents a 16-bit effective address to the execute stage.
- Sits between instruction decode, the memory interface and the ALU; the execute controller owns the ALU whenever alu_req is low.

Parameters:
- ALU_OP_ADDR, 8'b1000_0000, ALU operation code for address-calc add (f = a+b, carry = f[8]).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin sequence; sampled only in IDLE
- mode  in  3  0 zp, 1 zp+X, 2 zp+Y, 3 abs, 4 abs+X, 5 abs+Y, 6 (zp+X), 7 (zp)+Y
- is_write  in  1  store/RMW: FIX_HI cycle always taken on indexed abs and (zp)+Y
- index_x  in  8  X register
- index_y  in  8  Y register
- pc  in  16  address of next operand byte
- pc_inc  out  1  one-cycle pulse per completed operand fetch
- mem_addr  out  16  read address
- mem_rd  out  1  read request, held until mem_ready
- mem_data  in  8  read data, valid with mem_ready
- mem_ready  in  1  read completes at this clock edge
- alu_req  out  1  sequencer owns the ALU this cycle
- alu_a  out  8  ALU operand a
- alu_b  out  8  ALU operand b
- alu_op  out  8  ALU_OP_ADDR while alu_req, else 0
- alu_f  in  9  ALU result, combinational same cycle
- busy  out  1  high in every state except IDLE
- ea  out  16  effective address, held until the next start
- ea_valid  out  1  one-cycle pulse in DONE
- page_cross  out  1  index add carried into the high byte; valid with ea_valid, held

Behaviour:
- Reset (async, rst_n low): state IDLE.
  - All outputs 0.
  - Internal lo, hi and ptr registers cleared.
  - An operation in progress is abandoned; no ea_valid is issued.
- Start acceptance:
  - In IDLE, start=1 latches mode, is_write and the selected index (X for modes 1, 4 and 6; Y for modes 2, 5 and 7; 0 otherwise).
  - Next state is FETCH_LO.
  - start while busy is ignored.
- States: IDLE, FETCH_LO, FETCH_HI, ADD_LO, FIX_HI, PTR_LO, PTR_HI, DONE.
- Memory states (FETCH_LO, FETCH_HI, PTR_LO, PTR_HI):
  - mem_rd=1 and mem_addr stable until mem_ready.
  - Data is captured and the state advances at the mem_ready edge; otherwise the state is held (stall).
- FETCH_LO/FETCH_HI:
  - mem_addr=pc.
  - pc_inc pulses in the completing cycle.
  - FETCH_LO loads lo; FETCH_HI loads hi.
- ADD_LO:
  - alu_req=1, alu_a=lo, alu_b=index.
  - lo <= alu_f[7:0] and carry <= alu_f[8].
  - Single cycle.
- FIX_HI:
  - alu_req=1, alu_a=hi, alu_b=carry ? 8'h01 : 8'h00.
  - hi <= alu_f[7:0]; alu_f[8] is discarded (wrap 0xFFFF -> 0x0000).
- PTR_LO: mem_addr = {8'h00, ptr}.
- PTR_HI: mem_addr = {8'h00, ptr+1 mod 256} (zero-page wrap; 0xFF pointer reads 0x00FF then 0x0000).
- Transitions by mode:
  - zp (0): FETCH_LO -> DONE; hi=0.
  - zp+X/Y (1, 2): FETCH_LO -> ADD_LO -> DONE; hi=0; carry discarded (zero-page wrap); page_cross=0.
  - abs (3): FETCH_LO -> FETCH_HI -> DONE.
  - abs+X/Y (4, 5): FETCH_LO -> FETCH_HI -> ADD_LO -> (carry | is_write ? FIX_HI : DONE); FIX_HI -> DONE.
  - (zp+X) (6): FETCH_LO -> ADD_LO (ptr <= sum, carry discarded) -> PTR_LO -> PTR_HI -> DONE.
  - (zp)+Y (7): FETCH_LO (ptr <= data) -> PTR_LO -> PTR_HI -> ADD_LO -> (carry | is_write ? FIX_HI : DONE).
- DONE:
  - ea={hi, lo}, ea_valid=1 for exactly one cycle, then IDLE.
  - page_cross = carry from ADD_LO in modes 4, 5 and 7; 0 otherwise.
- Latency with mem_ready tied high: start edge to ea_valid.
  - zp: 2 cycles; zp+X: 3; abs: 3.
  - abs+X without cross: 4; with cross or write: 5.
  - (zp+X): 5; (zp)+Y: 5 or 6.
- alu_req is 0 outside ADD_LO/FIX_HI; alu_a and alu_b are 0 when not owned.

Test Plan:
- mode 1, operand 0xF0, X=0x20, mem_ready=1 -> ea=0x0010, page_cross=0, ea_valid 3 cycles after start, one pc_inc.
- mode 4, bytes 0xFF,0x12, X=0x01, is_write=0 -> FIX_HI taken, ea=0x1300, page_cross=1, ea_valid at cycle 5.
- mode 5, bytes 0x34,0x12, Y=0x10: is_write=0 -> ea=0x1244 at cycle 4, no FIX_HI; is_write=1 -> dummy FIX_HI (alu_b=0), ea=0x1244 at cycle 5.
- mode 7, operand 0xFF, mem[0x00FF]=0xF8, mem[0x0000]=0xFF, Y=0x10 -> reads 0x00FF then 0x0000, ea=0x0008 (16-bit wrap), page_cross=1.
- mode 6, operand 0x80, X=0x05, mem_ready low 3 cycles on PTR_LO -> mem_addr=0x0085 and mem_rd held through the stall, ea completes 3 cycles late.
- mode 3 with rst_n pulsed low during FETCH_HI -> immediate IDLE, all outputs 0, no ea_valid; start asserted while busy is ignored.
